spi_cmd_regfile: RTL and testbench
==================================

// Module: spi_cmd_regfile
// PURPOSE
//  Command/register stage directly downstream of the SPI slave byte engine. Consumes received
//  bytes (rx_byte/rx_valid), parses a command byte + data bytes per chip-select frame, reads or
//  writes a small register bank, and returns read data as tx_byte/tx_valid for the slave's shift
//  register. Register 1 drives the board LEDs.
// PARAMETERS
//  NREGS     8      number of 8-bit registers, 2..128; address width = clog2(NREGS)
//  ID_VALUE  8'h5A  read-only contents of register 0
//  BAD_RD    8'hEE  byte returned for a read of an address >= NREGS
// PORTS
//  clk         in   1  system clock
//  rst_n       in   1  reset, asynchronous, active-low
//  ssel_n      in   1  SPI chip select from pin, active-low, asynchronous to clk
//  rx_byte     in   8  received byte from the SPI slave, valid with rx_valid
//  rx_valid    in   1  1-clk pulse (clk domain): rx_byte complete
//  tx_byte     out  8  next byte for the SPI slave to shift out
//  tx_valid    out  1  1-clk pulse: load tx_byte into the slave
//  led         out  8  contents of register 1
//  wr_strobe   out  1  1-clk pulse on every accepted register write
//  wr_addr     out  7  address of the last accepted write
//  busy        out  1  1 while a frame is open (state != IDLE)
//  err         out  1  sticky: out-of-range access or write to reg 0; cleared by reset only
// BEHAVIOUR
//  - Reset: all outputs 0; registers 1..NREGS-1 = 0; state IDLE; ssel sync flops = 1.
//  - ssel_n passes through a 2-FF synchroniser; frame open = synced 0; frame close = synced 0->1.
//  - Command byte: bit7 = 1 read / 0 write; bits[6:0] = start address.
//  - FSM: IDLE -(synced ssel low)-> CMD -(rx_valid)-> DATA -(frame close)-> IDLE.
//    Frame close returns to IDLE from any state in the same cycle it is detected.
//  - CMD + rx_valid: latch rw/addr. Read: one clk later tx_byte = reg[addr]
//    (or BAD_RD and err=1 if addr >= NREGS), tx_valid pulses once.
//  - DATA + rx_valid, write: one clk later reg[addr] = rx_byte, wr_strobe pulses, wr_addr = addr.
//    addr == 0: no write, no strobe, err=1. addr >= NREGS: no write, no strobe, err=1.
//  - DATA + rx_valid, read: the byte is a dummy and is discarded. Next tx_byte is loaded one clk
//    later with tx_valid.
//  - Address width: addr held in 7 bits; range check against NREGS; no truncation aliasing.
//  - Simultaneous rx_valid and frame-close detection: close wins. The byte is discarded and the
//    FSM goes to IDLE.
//  - rx_valid in IDLE is ignored.
//  - tx_byte holds its last value between tx_valid pulses.
//  - led = reg[1], registered, no extra latency beyond the write cycle.
//  - Reset mid-frame: immediate return to reset values. The next frame needs a fresh ssel_n
//    low level.
// CONFIGURATION
//  SPI_REGS_AUTOINC_EN defined:
//   - After each DATA-phase byte (write) or each read tx load, addr increments by 1 (burst).
//   - Address wraps NREGS-1 -> 0.
//  SPI_REGS_AUTOINC_EN undefined:
//   - addr is fixed for the whole frame.
//   - Writes: only the first data byte is written; later bytes are ignored, no strobe, err not set.
//   - Reads: the same register is returned repeatedly.
// TESTING
//  1. Reset -> led=0, tx_valid=0, busy=0, err=0.
//     Frame {8'h01,8'h3C} -> led=8'h3C, one wr_strobe with wr_addr=1.
//  2. Frame {8'h80,dummy} -> tx_byte=8'h5A, tx_valid one clk after the cmd rx_valid; err stays 0.
//  3. Frame {8'h00,8'hFF} (write reg 0) -> no wr_strobe, err=1, reg 0 still reads 8'h5A.
//  4. Frame {8'h8A,..} with NREGS=8 -> tx_byte=8'hEE, err=1.
//  5. AUTOINC_EN: frame {8'h02,8'h11,8'h22,8'h33} -> regs 2,3,4 = 11,22,33, three wr_strobes.
//     Without the macro: only reg2=8'h11, one strobe.
//  6. ssel_n deasserted on the same synced cycle as a data rx_valid -> byte dropped, busy=0.
//     rst_n pulsed mid-burst -> all outputs at reset values.

Source files
------------

// File: rtl/spi_cmd_regfile.sv
// spi_cmd_regfile
//   Command/register stage behind the SPI slave byte engine. It parses one command
//   byte plus data bytes for each chip-select frame. It reads or writes a small
//   register bank and hands read data back to the slave as tx_byte/tx_valid.
//   Register 0 is a read-only ID. Register 1 drives the board LEDs.
//
// Optional feature (macro SPI_REGS_AUTOINC_EN):
//   defined   - the address increments after each write data byte and after each
//               read tx load (burst mode). It wraps from NREGS-1 to 0.
//   undefined - the address is fixed for the whole frame. Only the first write data
//               byte is used, and reads return the same register repeatedly.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   ssel_n     SPI chip select from the pin (active-low, asynchronous to clk)
//   rx_byte    received byte, qualified by rx_valid
//   rx_valid   1-clk pulse: rx_byte complete
//   tx_byte    next byte for the slave to shift out (holds between loads)
//   tx_valid   1-clk pulse: load tx_byte into the slave
//   led        contents of register 1
//   wr_strobe  1-clk pulse on every accepted register write
//   wr_addr    address of the last accepted write
//   busy       high while a frame is open
//   err        sticky out-of-range / reg-0 write flag, cleared by reset only
module spi_cmd_regfile #(
    parameter int unsigned NREGS    = 8,
    parameter logic [7:0]  ID_VALUE = 8'h5A,
    parameter logic [7:0]  BAD_RD   = 8'hEE
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ssel_n,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    output logic [7:0] tx_byte,
    output logic       tx_valid,
    output logic [7:0] led,
    output logic       wr_strobe,
    output logic [6:0] wr_addr,
    output logic       busy,
    output logic       err
);

    localparam int unsigned AW      = $clog2(NREGS);
    localparam logic [7:0]  NREGS_B = 8'(NREGS);

    typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

    state_e      state_q, state_d;
    logic        ssel_meta_q, ssel_meta_d;
    logic        ssel_sync_q, ssel_sync_d;
    logic        ssel_prev_q, ssel_prev_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic        done_q, done_d;
    logic [7:0]  regs_q [NREGS];
    logic [7:0]  regs_d [NREGS];
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        tx_valid_q, tx_valid_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic [6:0]  wr_addr_q, wr_addr_d;
    logic        busy_q, busy_d;
    logic        err_q, err_d;

    logic          frame_close;
    logic [6:0]    cur_addr;
    logic [AW-1:0] cur_idx;
    logic          cur_in_rng;
    logic [7:0]    rd_val;

`ifdef SPI_REGS_AUTOINC_EN
    localparam logic [6:0] LAST_ADDR = 7'(NREGS - 1);

    function automatic logic [6:0] addr_inc(input logic [6:0] a);
        return (a == LAST_ADDR) ? 7'd0 : a + 7'd1;
    endfunction
`endif

    // Closing edge of the synchronised chip select
    assign frame_close = ssel_sync_q & ~ssel_prev_q;

    // In CMD the address comes straight from the command byte. Otherwise it is the latched one.
    assign cur_addr   = (state_q == StCmd) ? rx_byte[6:0] : addr_q;
    assign cur_idx    = cur_addr[AW-1:0];
    // Full 7-bit compare so out-of-range addresses never alias onto real registers
    assign cur_in_rng = ({1'b0, cur_addr} < NREGS_B);

    always_comb begin
        rd_val = regs_q[cur_idx];
        if (!cur_in_rng) begin
            rd_val = BAD_RD;
        end else if (cur_addr == 7'd0) begin
            rd_val = ID_VALUE;
        end
    end

    always_comb begin
        ssel_meta_d = ssel_n;
        ssel_sync_d = ssel_meta_q;
        ssel_prev_d = ssel_sync_q;
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        done_d      = done_q;
        regs_d      = regs_q;
        tx_byte_d   = tx_byte_q;
        tx_valid_d  = 1'b0;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        err_d       = err_q;

        if (frame_close) begin
            // Close beats any coincident rx_valid. That byte is dropped.
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!ssel_sync_q) begin
                        state_d = StCmd;
                    end
                end
                StCmd: begin
                    if (rx_valid) begin
                        rw_d    = rx_byte[7];
                        addr_d  = rx_byte[6:0];
                        done_d  = 1'b0;
                        state_d = StData;
                        if (rx_byte[7]) begin
                            tx_byte_d  = rd_val;
                            tx_valid_d = 1'b1;
                            if (!cur_in_rng) begin
                                err_d = 1'b1;
                            end
`ifdef SPI_REGS_AUTOINC_EN
                            addr_d = addr_inc(rx_byte[6:0]);
`endif
                        end
                    end
                end
                StData: begin
                    if (rx_valid) begin
                        if (rw_q) begin
                            // Incoming byte is a dummy; answer with the next read
                            tx_byte_d  = rd_val;
                            tx_valid_d = 1'b1;
                            if (!cur_in_rng) begin
                                err_d = 1'b1;
                            end
`ifdef SPI_REGS_AUTOINC_EN
                            addr_d = addr_inc(addr_q);
`endif
                        end else if (!done_q) begin
                            if (cur_in_rng && (addr_q != 7'd0)) begin
                                regs_d[cur_idx] = rx_byte;
                                wr_strobe_d     = 1'b1;
                                wr_addr_d       = addr_q;
                            end else begin
                                err_d = 1'b1;
                            end
`ifdef SPI_REGS_AUTOINC_EN
                            addr_d = addr_inc(addr_q);
`else
                            done_d = 1'b1;
`endif
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ssel_meta_q <= 1'b1;
            ssel_sync_q <= 1'b1;
            ssel_prev_q <= 1'b1;
            state_q     <= StIdle;
            rw_q        <= 1'b0;
            addr_q      <= 7'd0;
            done_q      <= 1'b0;
            regs_q      <= '{default: '0};
            tx_byte_q   <= 8'd0;
            tx_valid_q  <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= 7'd0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ssel_meta_q <= ssel_meta_d;
            ssel_sync_q <= ssel_sync_d;
            ssel_prev_q <= ssel_prev_d;
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            done_q      <= done_d;
            regs_q      <= regs_d;
            tx_byte_q   <= tx_byte_d;
            tx_valid_q  <= tx_valid_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign tx_byte   = tx_byte_q;
    assign tx_valid  = tx_valid_q;
    assign led       = regs_q[1];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign busy      = busy_q;
    assign err       = err_q;

endmodule

// File: tb/tb_spi_cmd_regfile.sv
// Directed bench for spi_cmd_regfile (NREGS=8, ID 8'h5A, BAD_RD 8'hEE).
// Expectations track SPI_REGS_AUTOINC_EN when it is defined for the build.
module tb_spi_cmd_regfile;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ssel_n;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [7:0] led;
    logic       wr_strobe;
    logic [6:0] wr_addr;
    logic       busy;
    logic       err;

    int n_cmp = 0;
    int n_bad = 0;
    int strobe_cnt = 0;
    int tx_cnt = 0;
    int base;
    logic [7:0] d;

    spi_cmd_regfile dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ssel_n    (ssel_n),
        .rx_byte   (rx_byte),
        .rx_valid  (rx_valid),
        .tx_byte   (tx_byte),
        .tx_valid  (tx_valid),
        .led       (led),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt <= strobe_cnt + 1;
        if (tx_valid) tx_cnt <= tx_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic frame_open();
        ssel_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_close();
        ssel_n = 1'b1;
        tick(4);
    endtask

    // Returns one step after the edge that captured the byte
    task automatic send_byte(input logic [7:0] b);
        tick(1);
        rx_byte  = b;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic read_reg(input logic [6:0] a, output logic [7:0] v);
        frame_open();
        send_byte({1'b1, a});
        check_eq("rd_tx_valid", 32'(tx_valid), 32'd1);
        v = tx_byte;
        frame_close();
    endtask

    initial begin
        rst_n    = 1'b0;
        ssel_n   = 1'b1;
        rx_byte  = 8'd0;
        rx_valid = 1'b0;
        tick(3);
        check_eq("rst_led_in", 32'(led), 32'h0);
        check_eq("rst_busy_in", 32'(busy), 32'h0);
        rst_n = 1'b1;
        tick(2);
        check_eq("rst_led", 32'(led), 32'h0);
        check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_tx_byte", 32'(tx_byte), 32'h0);

        // Write reg 1 -> LEDs
        base = strobe_cnt;
        frame_open();
        check_eq("t1_busy_open", 32'(busy), 32'h1);
        send_byte(8'h01);
        send_byte(8'h3C);
        check_eq("t1_strobe", 32'(wr_strobe), 32'h1);
        check_eq("t1_wr_addr", 32'(wr_addr), 32'h1);
        check_eq("t1_led", 32'(led), 32'h3C);
        frame_close();
        check_eq("t1_strobe_cnt", 32'(strobe_cnt - base), 32'd1);
        check_eq("t1_busy_closed", 32'(busy), 32'h0);

        // Read ID register, then one dummy byte
        base = tx_cnt;
        frame_open();
        send_byte(8'h80);
        check_eq("t2_tx_valid", 32'(tx_valid), 32'h1);
        check_eq("t2_tx_byte", 32'(tx_byte), 32'h5A);
        tick(1);
        check_eq("t2_tx_pulse", 32'(tx_valid), 32'h0);
        check_eq("t2_tx_hold", 32'(tx_byte), 32'h5A);
        send_byte(8'hA5);
        check_eq("t2_tx_valid2", 32'(tx_valid), 32'h1);
`ifdef SPI_REGS_AUTOINC_EN
        check_eq("t2_tx_byte2", 32'(tx_byte), 32'h3C);
`else
        check_eq("t2_tx_byte2", 32'(tx_byte), 32'h5A);
`endif
        frame_close();
        check_eq("t2_tx_cnt", 32'(tx_cnt - base), 32'd2);
        check_eq("t2_err", 32'(err), 32'h0);

        // Write to read-only reg 0
        base = strobe_cnt;
        frame_open();
        send_byte(8'h00);
        send_byte(8'hFF);
        check_eq("t3_strobe", 32'(wr_strobe), 32'h0);
        check_eq("t3_err", 32'(err), 32'h1);
        frame_close();
        check_eq("t3_strobe_cnt", 32'(strobe_cnt - base), 32'd0);
        read_reg(7'h00, d);
        check_eq("t3_reg0", 32'(d), 32'h5A);

        // Out-of-range read
        do_reset();
        check_eq("t4_err_cleared", 32'(err), 32'h0);
        read_reg(7'h0A, d);
        check_eq("t4_bad_rd", 32'(d), 32'hEE);
        check_eq("t4_err", 32'(err), 32'h1);

        // Burst write
        do_reset();
        base = strobe_cnt;
        frame_open();
        send_byte(8'h02);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        frame_close();
        check_eq("t5_err", 32'(err), 32'h0);
`ifdef SPI_REGS_AUTOINC_EN
        check_eq("t5_strobe_cnt", 32'(strobe_cnt - base), 32'd3);
`else
        check_eq("t5_strobe_cnt", 32'(strobe_cnt - base), 32'd1);
`endif
        read_reg(7'h02, d);
        check_eq("t5_reg2", 32'(d), 32'h11);
        read_reg(7'h03, d);
`ifdef SPI_REGS_AUTOINC_EN
        check_eq("t5_reg3", 32'(d), 32'h22);
`else
        check_eq("t5_reg3", 32'(d), 32'h00);
`endif
        read_reg(7'h04, d);
`ifdef SPI_REGS_AUTOINC_EN
        check_eq("t5_reg4", 32'(d), 32'h33);
`else
        check_eq("t5_reg4", 32'(d), 32'h00);
`endif

        // Data byte coincident with the synced frame close
        base = strobe_cnt;
        frame_open();
        send_byte(8'h05);
        ssel_n = 1'b1;
        tick(2);
        rx_byte  = 8'hAB;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
        check_eq("t6_busy", 32'(busy), 32'h0);
        check_eq("t6_strobe", 32'(wr_strobe), 32'h0);
        tick(3);
        check_eq("t6_strobe_cnt", 32'(strobe_cnt - base), 32'd0);
        read_reg(7'h05, d);
        check_eq("t6_reg5", 32'(d), 32'h00);

        // Reset in the middle of a burst
        frame_open();
        send_byte(8'h00);
        send_byte(8'h99);
        frame_close();
        check_eq("t6_err_pre", 32'(err), 32'h1);
        frame_open();
        send_byte(8'h01);
        send_byte(8'h77);
        check_eq("t6_led_pre", 32'(led), 32'h77);
        send_byte(8'h88);
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_led", 32'(led), 32'h0);
        check_eq("t6_rst_busy", 32'(busy), 32'h0);
        check_eq("t6_rst_err", 32'(err), 32'h0);
        check_eq("t6_rst_tx_valid", 32'(tx_valid), 32'h0);
        check_eq("t6_rst_tx_byte", 32'(tx_byte), 32'h0);
        check_eq("t6_rst_wr_strobe", 32'(wr_strobe), 32'h0);
        check_eq("t6_rst_wr_addr", 32'(wr_addr), 32'h0);
        ssel_n = 1'b1;
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check_eq("t6_post_busy", 32'(busy), 32'h0);
        check_eq("t6_post_led", 32'(led), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
